// File: rtl/fmadd_mul_seq_mantissa_pkg.sv
// Shared definitions for the iterative FMADD multiply front-end: FSM encoding,
// operand class decode and the FP32 / bfloat16 parameter sets.
package fmadd_mul_seq_mantissa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_LZC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic pos;
    logic neg;
    logic sub;
  } op_class_t;

  localparam int FP32_STD  = 31;
  localparam int FP32_MAN  = 22;
  localparam int FP32_EXP  = 7;
  localparam int FP32_BIAS = 127;
  localparam int FP32_LZD  = 4;

  localparam int BF16_STD  = 15;
  localparam int BF16_MAN  = 6;
  localparam int BF16_EXP  = 7;
  localparam int BF16_BIAS = 127;
  localparam int BF16_LZD  = 3;

  // Exponent field and bias arrive zero-extended to 16 bits so one function
  // serves every format; exactly one flag is ever set.
  function automatic op_class_t class_decode(input logic [15:0] e, input logic [15:0] b);
    op_class_t c;
    c.sub = (e == 16'd0);
    c.pos = (e >= b) && (e != 16'd0);
    c.neg = (e != 16'd0) && (e < b);
    return c;
  endfunction

endpackage

// File: rtl/fmadd_lzc_prio.sv
// Leading-zero counter returning clz(d) - 1, clamped to [0, 2^ow - 1].
// An all-zero input therefore saturates to the maximum code.
module fmadd_lzc_prio #(
  parameter int w  = 48,
  parameter int ow = 5
) (
  input  logic [w-1:0]  d,
  output logic [ow-1:0] cnt
);

  localparam int CNT_MAX = (1 << ow) - 1;

  int clz;

  always_comb begin
    clz = w;
    // Scan upward so the most significant set bit wins.
    for (int i = 0; i < w; i++) begin
      if (d[i]) clz = w - 1 - i;
    end
    if (clz == 0)                cnt = '0;
    else if (clz - 1 > CNT_MAX)  cnt = ow'(CNT_MAX);
    else                         cnt = ow'(clz - 1);
  end

endmodule

// File: rtl/fmadd_mul_seq_mantissa.sv
// Iterative multiply front-end: class decode, sign, double-biased exponent sum,
// radix-2 shift-add significand product and leading-zero count.
module fmadd_mul_seq_mantissa
  import fmadd_mul_seq_mantissa_pkg::*;
#(
  parameter int std  = FP32_STD,
  parameter int man  = FP32_MAN,
  parameter int exp  = FP32_EXP,
  parameter int bias = FP32_BIAS,
  parameter int lzd  = FP32_LZD
) (
  input  logic               clk,
  input  logic               rst_l,
  // Both sides are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the result is held until out_ready.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [std:0]       in_a,
  input  logic [std:0]       in_b,
  input  logic [2:0]         in_rm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [exp+1:0]     out_exp_DB,
  output logic [2*man+3:0]   out_multiplied_man,
  output logic [lzd:0]       out_lzd,
  output logic [2:0]         out_rm,
  output logic               out_A_pos,
  output logic               out_A_neg,
  output logic               out_A_sub,
  output logic               out_B_pos,
  output logic               out_B_neg,
  output logic               out_B_sub,
  output logic [1:0]         dbg_state
);

  localparam int SW = man + 2;
  localparam int PW = 2 * man + 4;
  localparam int EW = exp + 2;
  localparam int CW = $clog2(SW + 1);

  state_t state, next_state;

  logic [CW-1:0] cnt;
  logic [PW-1:0] mcand;
  logic [SW-1:0] mplier;
  logic [PW-1:0] acc;
  logic [lzd:0]  lzc_cnt;

  logic [exp:0]  a_exp, b_exp, a_eff, b_eff;
  logic [SW-1:0] a_sig, b_sig;
  logic [EW-1:0] exp_sum;
  op_class_t     a_cls, b_cls;

  assign a_exp = in_a[std-1 -: exp+1];
  assign b_exp = in_b[std-1 -: exp+1];
  assign a_cls = class_decode(16'(a_exp), 16'(bias));
  assign b_cls = class_decode(16'(b_exp), 16'(bias));
  // The hidden bit is simply "exponent field non-zero".
  assign a_sig = {|a_exp, in_a[man:0]};
  assign b_sig = {|b_exp, in_b[man:0]};
  assign a_eff = a_cls.sub ? (exp+1)'(1) : a_exp;
  assign b_eff = b_cls.sub ? (exp+1)'(1) : b_exp;
  assign exp_sum = EW'(a_eff) + EW'(b_eff);

  fmadd_lzc_prio #(.w(PW), .ow(lzd + 1)) u_lzc (
    .d   (acc),
    .cnt (lzc_cnt)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (in_valid)            next_state = ST_MUL;
      ST_MUL:  if (cnt == CW'(1))       next_state = ST_LZC;
      ST_LZC:                           next_state = ST_DONE;
      ST_DONE: if (out_ready)           next_state = ST_IDLE;
      default:                          next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      out_sign   <= 1'b0;
      out_exp_DB <= '0;
      out_lzd    <= '0;
      out_rm     <= '0;
      out_A_pos  <= 1'b0;
      out_A_neg  <= 1'b0;
      out_A_sub  <= 1'b0;
      out_B_pos  <= 1'b0;
      out_B_neg  <= 1'b0;
      out_B_sub  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          out_sign   <= in_a[std] ^ in_b[std];
          out_exp_DB <= exp_sum;
          out_rm     <= in_rm;
          {out_A_pos, out_A_neg, out_A_sub} <= a_cls;
          {out_B_pos, out_B_neg, out_B_sub} <= b_cls;
          acc        <= '0;
          cnt        <= CW'(SW);
          mcand      <= PW'(a_sig);
          mplier     <= b_sig;
        end
        ST_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        ST_LZC:  out_lzd <= lzc_cnt;
        default: ;
      endcase
    end
  end

  assign in_ready           = (state == ST_IDLE);
  assign out_valid          = (state == ST_DONE);
  assign out_multiplied_man = acc;
  assign dbg_state          = state;

endmodule

// File: tb/tb_fmadd_mul_seq_mantissa.sv
// Bench for fmadd_mul_seq_mantissa (FP32 parameters): directed vector table,
// random vectors against a reference model, backpressure, overlap and abort.
module tb_fmadd_mul_seq_mantissa;

  localparam int MAN = 22;
  localparam int LAT = MAN + 4;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp_db;
    logic [47:0] prod;
    logic [4:0]  lzd;
    logic [5:0]  flags;
    logic [2:0]  rm;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    int          hold;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_rm, out_rm;
  logic        out_sign;
  logic [8:0]  out_exp_DB;
  logic [47:0] out_multiplied_man;
  logic [4:0]  out_lzd;
  logic        out_A_pos, out_A_neg, out_A_sub, out_B_pos, out_B_neg, out_B_sub;
  logic [1:0]  dbg_state;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  fmadd_mul_seq_mantissa dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp_DB(out_exp_DB), .out_multiplied_man(out_multiplied_man), .out_lzd(out_lzd),
    .out_rm(out_rm), .out_A_pos(out_A_pos), .out_A_neg(out_A_neg), .out_A_sub(out_A_sub),
    .out_B_pos(out_B_pos), .out_B_neg(out_B_neg), .out_B_sub(out_B_sub),
    .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- helpers ----
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [8:0] e, input logic [47:0] p,
                              input logic [4:0] l, input logic [5:0] f, input logic [2:0] rm);
    exp_t r;
    r.sign = s; r.exp_db = e; r.prod = p; r.lzd = l; r.flags = f; r.rm = rm;
    return r;
  endfunction

  function automatic logic [2:0] cls(input logic [7:0] e);
    if (e == 8'd0)       return 3'b001;
    else if (e >= 8'd127) return 3'b100;
    else                 return 3'b010;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    exp_t        r;
    logic [47:0] sa, sb;
    int          ea, eb, clz;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    sa = {24'd0, (a[30:23] != 8'd0), a[22:0]};
    sb = {24'd0, (b[30:23] != 8'd0), b[22:0]};
    r.sign   = a[31] ^ b[31];
    r.exp_db = 9'(ea + eb);
    r.prod   = sa * sb;
    clz = 48;
    for (int i = 47; i >= 0; i--) begin
      if (r.prod[i] && clz == 48) clz = 47 - i;
    end
    r.lzd   = (clz == 0) ? 5'd0 : ((clz - 1 > 31) ? 5'd31 : 5'(clz - 1));
    r.flags = {cls(a[30:23]), cls(b[30:23])};
    r.rm    = rm;
    return r;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, "_sign"},  64'(out_sign), 64'(e.sign));
    check({tag, "_exp"},   64'(out_exp_DB), 64'(e.exp_db));
    check({tag, "_prod"},  64'(out_multiplied_man), 64'(e.prod));
    check({tag, "_lzd"},   64'(out_lzd), 64'(e.lzd));
    check({tag, "_flags"}, 64'({out_A_pos, out_A_neg, out_A_sub, out_B_pos, out_B_neg, out_B_sub}),
          64'(e.flags));
    check({tag, "_rm"},    64'(out_rm), 64'(e.rm));
  endtask

  // ---- driver ----
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                      input exp_t e);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_rm = rm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_rm = 3'($urandom_range(0, 7));
    exp_q.push_back(e);
  endtask

  // Called at #1 after the accept edge (cycle 1).
  task automatic receive(input string tag, input int hold);
    exp_t e;
    int   cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_valid_timeout"}, 64'(out_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    compare_all(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      compare_all({tag, "_hold"}, e);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // ---- stimulus and scoreboard ----
  initial begin
    exp_t e;
    logic [31:0] ra, rb;
    logic [2:0]  rrm;

    vecs[0] = '{32'h3F800000, 32'h3F800000, 3'd0, 0, mk(0, 9'd254, 48'h4000_0000_0000, 5'd0,  6'b100100, 3'd0)};
    vecs[1] = '{32'h3FC00000, 32'h3FC00000, 3'd1, 0, mk(0, 9'd254, 48'h9000_0000_0000, 5'd0,  6'b100100, 3'd1)};
    vecs[2] = '{32'h3F800000, 32'h00000001, 3'd2, 0, mk(0, 9'd128, 48'h0000_0080_0000, 5'd23, 6'b100001, 3'd2)};
    vecs[3] = '{32'hC0000000, 32'h40400000, 3'd3, 10, mk(1, 9'd256, 48'h6000_0000_0000, 5'd0, 6'b100100, 3'd3)};
    vecs[4] = '{32'h3E800000, 32'h00000000, 3'd4, 0, mk(0, 9'd126, 48'h0, 5'd31, 6'b010001, 3'd4)};
    vecs[5] = '{32'h80400000, 32'h00400000, 3'd5, 0, mk(1, 9'd2,   48'h1000_0000_0000, 5'd2,  6'b001001, 3'd5)};
    vecs[6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 3'd6, 2, mk(0, 9'd508, 48'hFFFF_FE00_0001, 5'd0,  6'b100100, 3'd6)};
    vecs[7] = '{32'h00800000, 32'h3F000000, 3'd7, 0, mk(0, 9'd127, 48'h4000_0000_0000, 5'd0,  6'b010010, 3'd7)};

    rst_l = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_rm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    compare_all("rst", '0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].e);
      receive($sformatf("vec%0d", i), vecs[i].hold);
    end

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rrm = 3'($urandom_range(0, 7));
      if (i < 2) ra[30:23] = 8'd0;
      send(ra, rb, rrm, model(ra, rb, rrm));
      receive($sformatf("rnd%0d", i), $urandom_range(0, 3));
    end

    // in_valid present during the output handshake must wait for the next IDLE cycle.
    send(32'h3FC00000, 32'h3FC00000, 3'd1, vecs[1].e);
    begin
      int n = 1;
      while (!out_valid && n < 200) begin
        @(posedge clk); #1; n++;
      end
    end
    check("ovl_valid", 64'(out_valid), 64'd1);
    e = exp_q.pop_front();
    compare_all("ovl_first", e);
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h00000001; in_rm = 3'd2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovl_not_accepted", 64'(dbg_state), 64'd0);
    check("ovl_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(vecs[2].e);
    check("ovl_accepted", 64'(dbg_state), 64'd1);
    receive("ovl_second", 0);

    // Asynchronous reset in the middle of MUL discards the partial product.
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 3'd6, vecs[6].e);
    repeat (11) @(posedge clk);
    #1;
    check("abort_in_mul", 64'(dbg_state), 64'd1);
    rst_l = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    compare_all("abort", '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_l = 1'b1;
    @(posedge clk); #1;
    send(vecs[2].a, vecs[2].b, vecs[2].rm, vecs[2].e);
    receive("after_abort", 0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmadd_mul_seq_mantissa.md
# fmadd_mul_seq_mantissa

Iterative front-end of the FMADD multiply path. It accepts two packed IEEE-style operands (FP32 by default; bfloat16 by parameter override) and classifies each as pos, neg or sub. It forms the sign and the double-biased exponent sum, builds the full-width mantissa product with a radix-2 shift-add engine, and computes the leading-zero count of the product. Its registered outputs drive the multiply post-normalization stage directly.

## Interface
- `std`, 31: operand width − 1
- `man`, 22: stored mantissa bits − 1
- `exp`, 7: exponent bits − 1
- `bias`, 127: exponent bias
- `lzd`, 4: LZD output width − 1
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_l`  in  1  reset; asynchronous, active-low
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block can accept operands
- `in_a`, `in_b`  in  std+1  packed operands {sign, exp, man}
- `in_rm`  in  3  rounding mode, registered and passed through
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_sign`  out  1  sign of A XOR sign of B
- `out_exp_DB`  out  exp+2  effective exponent of A + effective exponent of B
- `out_multiplied_man`  out  2·man+4  unsigned product of the two significands
- `out_lzd`  out  lzd+1  clz(product) − 1, clamped to the range [0, 2^(lzd+1) − 1]
- `out_rm`  out  3  registered copy of `in_rm`
- `out_A_pos`, `out_A_neg`, `out_A_sub`, `out_B_pos`, `out_B_neg`, `out_B_sub`  out  1 each  operand class flags

## Operation
- Classes:
  - sub: exp field = 0.
  - pos: exp field ≥ bias.
  - neg: 0 < exp field < bias.
  - Exactly one class flag is set per operand.
- Significand:
  - Normal: {1, man}.
  - Sub: {0, man}.
  - Effective exponent is the exp field; a sub operand contributes 1.
- The sum uses exp+2 bits and never overflows. Maximum is 2·(2^(exp+1) − 2).
- FSM states:
  - IDLE: `in_ready` = 1. On `in_valid`, latch operands, sign, exp_DB, classes and rm. Clear the accumulator, load counter = man+2, go to MUL.
  - MUL: each cycle, if multiplier LSB = 1, add the shifted multiplicand into the accumulator. Then shift the multiplicand left and the multiplier right, and decrement the counter. When the counter reaches 0 after the update, go to LZC.
  - LZC: register `out_lzd` from a combinational priority encoder over the 2·man+4-bit product, then go to DONE.
  - DONE: `out_valid` = 1. All outputs are held stable. On `out_ready`, go to IDLE.
- Zero operand (sub with man = 0):
  - Runs the full sequence with no early-out.
  - Product = 0; `out_lzd` = saturated maximum.
- NaN and Inf are not special-cased; they are handled in a separate exception path.

## Timing
- Reset: state = IDLE, `in_ready` = 1, `out_valid` = 0. All data outputs, flags, the accumulator and the counter are 0.
- Accept edge = cycle 0. MUL occupies cycles 1..man+2, LZC is cycle man+3, and `out_valid` rises at cycle man+4. FP32 latency is 26 cycles.
- `in_ready` is low from cycle 1 until the cycle after the output handshake, so there is no overlap. Throughput is one op per man+5 cycles at best.
- Operands and the rm input may change freely after the accept edge.
- Backpressure: while `out_valid` && !`out_ready`, every output is held bit-stable indefinitely.
- If `in_valid` is asserted during an output handshake cycle, it is ignored. It is accepted in the following IDLE cycle.
- `rst_l` low in any state forces the reset values immediately. The partial product is discarded.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/MUL/LZC/DONE).
  - Class-decode function.
  - Parameter set constants for FP32 and bfloat16 (man = 6, exp = 7, lzd = 3).
- One sub-module, `fmadd_lzc_prio`: a parameterized leading-zero counter producing clz − 1 with clamping. It is reused elsewhere in the FMADD datapath.

## Test plan
- A = B = 0x3F800000 → sign 0, exp_DB 254, product 0x4000_0000_0000, A_pos = B_pos = 1, `out_valid` exactly 26 cycles after accept.
- A = B = 0x3FC00000 (1.5) → product 0x9000_0000_0000, bit 47 set, `out_lzd` = 0.
- A = 0x3F800000, B = 0x00000001 → B_sub = 1, exp_DB 128, product 0x80_0000, `out_lzd` = 23 (clamped to 15 for bfloat16 params).
- A = 0xC0000000, B = 0x40400000 → sign 1, exp_DB 256, product 0x6000_0000_0000; hold `out_ready` low 10 cycles: outputs stable, `in_ready` low.
- A = 0x3E800000, B = 0x00000000 → A_neg = 1, B_sub = 1, product 0, `out_lzd` = 31.
- Drop `rst_l` at cycle 12 of MUL → reset values immediately. Next operands produce correct results with no residue from the aborted operation.
